// File: rtl/mem_write_buffer.sv
// ---------------------------------------------------------------------------
// mem_write_buffer
//
// Bridge between the core's memory port and a single-port synchronous data
// memory. Core writes are posted into a small FIFO and drained to memory one
// per cycle while the bridge is idle. Core reads are only accepted once the
// FIFO is empty, so a read always observes the newest written data.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   core_req_*       : core request channel (valid/ready handshake)
//   core_rsp_valid   : one-cycle pulse, read data available
//   core_rsp_rdata   : read data, held until the next response
//   mem_addr/wdata   : memory address / write data
//   mem_we / mem_re  : memory write / read strobes (never both high)
//   mem_rdata        : memory read data, valid the cycle after an accepted read
//   mem_ready        : memory can take an operation this cycle
//   buf_count        : number of occupied FIFO entries
// ---------------------------------------------------------------------------
module mem_write_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req_valid,
    input  logic                  core_req_we,
    input  logic [DATA_WIDTH-1:0] core_req_addr,
    input  logic [DATA_WIDTH-1:0] core_req_wdata,
    output logic                  core_req_ready,
    output logic                  core_rsp_valid,
    output logic [DATA_WIDTH-1:0] core_rsp_rdata,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [CNT_W-1:0]      buf_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t state_q, state_d;

    // FIFO storage: small enough to live in registers, so no reset and a
    // combinational head read.
    logic [DATA_WIDTH-1:0] fifo_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];

    // Ready depends on the request type. The write side looks only at the
    // pre-pop occupancy, so a full FIFO refuses a write even while draining.
    // Reads wait until every posted write has reached memory.
    always_comb begin
        core_req_ready = 1'b0;
        if (core_req_we) begin
            core_req_ready = !fifo_full;
        end else begin
            core_req_ready = fifo_empty && (state_q == IDLE);
        end
    end

    assign push      = core_req_valid && core_req_we && !fifo_full;
    assign rd_accept = core_req_valid && !core_req_we && fifo_empty && (state_q == IDLE);
    assign pop       = (state_q == IDLE) && !fifo_empty && mem_ready;

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_addr_q[wr_ptr_q] <= core_req_addr;
            fifo_data_q[wr_ptr_q] <= core_req_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Read-sequencing FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (rd_accept) begin
                    rd_addr_d = core_req_addr;
                    state_d   = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                // The read only counts once the memory has taken it.
                if (mem_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Memory data is valid in the cycle after the accepted read.
                rsp_rdata_d = mem_rdata;
                state_d     = RD_RESP;
            end
            RD_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_addr_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_addr_q   <= rd_addr_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Memory-side outputs: sourced from the FIFO head or the latched read
    // address only, never from the core request inputs. Address/data fall
    // back to zero when no operation is pending so the bus is quiet after
    // reset.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if ((state_q == IDLE) && !fifo_empty) begin
            mem_addr  = head_addr;
            mem_wdata = head_data;
            mem_we    = mem_ready;
        end else if (state_q == RD_ISSUE) begin
            mem_addr = rd_addr_q;
            mem_re   = mem_ready;
        end
    end

    assign core_rsp_valid = (state_q == RD_RESP);
    assign core_rsp_rdata = rsp_rdata_q;
    assign buf_count      = count_q;

endmodule
